// File: rtl/music_box_pkg.sv
// Shared types and constants for the music box mode controller.
package music_box_pkg;

    localparam int SONG_IDX_W = 3;

    localparam logic [3:0] MODE_IDLE    = 4'd0;
    localparam logic [3:0] MODE_SONG    = 4'd1;
    localparam logic [3:0] MODE_PLAYREC = 4'd3;
    localparam logic [3:0] MODE_MAKEREC = 4'd4;
    localparam logic [3:0] MODE_ERROR   = 4'd8;

    // State encoding doubles as the external mode code.
    typedef enum logic [3:0] {
        IDLE      = MODE_IDLE,
        PLAY_SONG = MODE_SONG,
        PLAY_REC  = MODE_PLAYREC,
        MAKE_REC  = MODE_MAKEREC,
        ERROR     = MODE_ERROR
    } mode_t;

endpackage

// File: rtl/music_box_debouncer.sv
// Active-low button debouncer clocked by a 1 ms tick strobe.
module music_box_debouncer #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clock_50Mhz,
    input  logic reset,
    input  logic tick_1khz,
    input  logic button_n,
    output logic pressed
);

    localparam logic [7:0] LIMIT = 8'(DEBOUNCE_MS);

    logic [7:0] count;

    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            count <= '0;
        end else if (button_n) begin
            count <= '0;
        end else if (tick_1khz && count != LIMIT) begin
            count <= count + 8'd1;
        end
    end

    // Fires only on the tick that lands on the limit; saturation blocks repeats.
    assign pressed = !button_n && tick_1khz && (count == LIMIT - 8'd1);

endmodule

// File: rtl/music_box_mode_controller.sv
// Music box mode arbiter: debounced buttons select song/playback/record modes.
// Define MUSICBOX_WATCHDOG_EN to enable the per-mode timeout into ERROR.
module music_box_mode_controller
    import music_box_pkg::*;
#(
    parameter int NUM_SONGS   = 2,
    parameter int DEBOUNCE_MS = 20,
    parameter int TIMEOUT_MS  = 600000
) (
    input  logic                  clock_50Mhz,
    input  logic                  reset,
    input  logic                  tick_1khz,
    input  logic [NUM_SONGS-1:0]  input_PlaySong_n,
    input  logic                  input_PlayRecording_n,
    input  logic                  input_MakeRecording_n,
    input  logic                  input_Stop_n,
    input  logic                  recording_valid,
    input  logic                  done_song,
    input  logic                  done_playback,
    input  logic                  done_record,
    output logic [3:0]            outputState,
    output logic [SONG_IDX_W-1:0] song_index,
    output logic                  mode_start,
    output logic                  mode_abort,
    output logic [31:0]           debugString
);

    localparam int NB = NUM_SONGS + 3;
    localparam int I_PREC = NUM_SONGS;
    localparam int I_MAKE = NUM_SONGS + 1;
    localparam int I_STOP = NUM_SONGS + 2;
    localparam logic [23:0] WD_LIMIT = 24'(TIMEOUT_MS);

    logic [NB-1:0] raw_n;
    logic [NB-1:0] press;

    assign raw_n = {input_Stop_n, input_MakeRecording_n,
                    input_PlayRecording_n, input_PlaySong_n};

    for (genvar g = 0; g < NB; g++) begin : g_deb
        music_box_debouncer #(
            .DEBOUNCE_MS(DEBOUNCE_MS)
        ) u_deb (
            .clock_50Mhz(clock_50Mhz),
            .reset      (reset),
            .tick_1khz  (tick_1khz),
            .button_n   (raw_n[g]),
            .pressed    (press[g])
        );
    end

    mode_t                 state_q, state_d;
    logic [SONG_IDX_W-1:0] song_q, song_d, song_sel;
    logic                  start_q, start_d;
    logic                  abort_q, abort_d;
    logic [23:0]           elapsed_q;
    logic                  active;
    logic                  wd;
    logic                  ev_song;

    assign active = (state_q == PLAY_SONG) || (state_q == PLAY_REC) ||
                    (state_q == MAKE_REC);
    assign ev_song = |press[NUM_SONGS-1:0];

`ifdef MUSICBOX_WATCHDOG_EN
    assign wd = active && (elapsed_q >= WD_LIMIT);
`else
    logic unused_wd_limit;
    assign unused_wd_limit = ^WD_LIMIT;
    assign wd = 1'b0;
`endif

    always_comb begin
        song_sel = '0;
        for (int i = 0; i < NUM_SONGS; i++) begin
            if (press[i]) song_sel = SONG_IDX_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        song_d  = song_q;
        start_d = 1'b0;
        abort_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (press[I_MAKE]) begin
                    state_d = MAKE_REC;
                    start_d = 1'b1;
                end else if (press[I_PREC] && recording_valid) begin
                    state_d = PLAY_REC;
                    start_d = 1'b1;
                end else if (ev_song) begin
                    state_d = PLAY_SONG;
                    song_d  = song_sel;
                    start_d = 1'b1;
                end
            end
            PLAY_SONG, PLAY_REC, MAKE_REC: begin
                if (wd) begin
                    state_d = ERROR;
                end else if ((state_q == PLAY_SONG && done_song) ||
                             (state_q == PLAY_REC && done_playback) ||
                             (state_q == MAKE_REC && done_record)) begin
                    state_d = IDLE;
                end else if (press[I_STOP]) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end
            end
            ERROR: state_d = ERROR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            state_q   <= IDLE;
            song_q    <= '0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
            elapsed_q <= '0;
        end else begin
            state_q <= state_d;
            song_q  <= song_d;
            start_q <= start_d;
            abort_q <= abort_d;
            if (start_d) begin
                elapsed_q <= '0;
            end else if (active && tick_1khz && elapsed_q != '1) begin
                elapsed_q <= elapsed_q + 24'd1;
            end
        end
    end

    assign outputState = state_q;
    assign song_index  = song_q;
    assign mode_start  = start_q;
    assign mode_abort  = abort_q;
    assign debugString = {4'd0, state_q, 5'd0, song_q,
                          (|elapsed_q[23:16]) ? 16'hFFFF : elapsed_q[15:0]};

endmodule

// File: tb/tb_music_box_mode_controller.sv
// Directed vector bench for music_box_mode_controller (NUM_SONGS=2, 20 ms debounce).
module tb_music_box_mode_controller;

    logic       clock_50Mhz;
    logic       reset;
    logic       tick_1khz;
    logic [1:0] song_n;
    logic       prec_n, make_n, stop_n, rv;
    logic       ds, dp, dr;
    logic [3:0] outputState;
    logic [2:0] song_index;
    logic       mode_start, mode_abort;
    logic [31:0] debugString;

    int nvec = 0;
    int nbad = 0;

    music_box_mode_controller #(
        .NUM_SONGS  (2),
        .DEBOUNCE_MS(20)
    ) dut (
        .clock_50Mhz          (clock_50Mhz),
        .reset                (reset),
        .tick_1khz            (tick_1khz),
        .input_PlaySong_n     (song_n),
        .input_PlayRecording_n(prec_n),
        .input_MakeRecording_n(make_n),
        .input_Stop_n         (stop_n),
        .recording_valid      (rv),
        .done_song            (ds),
        .done_playback        (dp),
        .done_record          (dr),
        .outputState          (outputState),
        .song_index           (song_index),
        .mode_start           (mode_start),
        .mode_abort           (mode_abort),
        .debugString          (debugString)
    );

`ifdef MUSICBOX_WATCHDOG_EN
    logic [3:0]  wd_state;
    logic [2:0]  wd_idx;
    logic        wd_start, wd_abort;
    logic [31:0] wd_dbg;

    music_box_mode_controller #(
        .NUM_SONGS  (2),
        .DEBOUNCE_MS(20),
        .TIMEOUT_MS (5)
    ) dut_wd (
        .clock_50Mhz          (clock_50Mhz),
        .reset                (reset),
        .tick_1khz            (tick_1khz),
        .input_PlaySong_n     (song_n),
        .input_PlayRecording_n(prec_n),
        .input_MakeRecording_n(make_n),
        .input_Stop_n         (stop_n),
        .recording_valid      (rv),
        .done_song            (ds),
        .done_playback        (dp),
        .done_record          (dr),
        .outputState          (wd_state),
        .song_index           (wd_idx),
        .mode_start           (wd_start),
        .mode_abort           (wd_abort),
        .debugString          (wd_dbg)
    );
`endif

    initial begin
        clock_50Mhz = 1'b0;
        forever #5 clock_50Mhz = ~clock_50Mhz;
    end

    typedef struct {
        string      name;
        logic [1:0] song_n;
        logic       prec_n, make_n, stop_n, rv, ds, dp, dr;
        int         ticks;
        logic [3:0] st;
        logic [2:0] idx;
        logic       start, abort;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl[NV];

    task automatic cyc(input int n);
        repeat (n) @(posedge clock_50Mhz);
        #1;
    endtask

    task automatic ticks(input int n);
        tick_1khz = 1'b1;
        cyc(n);
        tick_1khz = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [3:0] st,
                           input logic [2:0] idx, input logic s,
                           input logic a);
        chk({nm, ".state"}, 32'(outputState), 32'(st));
        chk({nm, ".idx"},   32'(song_index),  32'(idx));
        chk({nm, ".start"}, 32'(mode_start),  32'(s));
        chk({nm, ".abort"}, 32'(mode_abort),  32'(a));
    endtask

    initial begin
        //          name          song  pr mk st rv ds dp dr tk  st    idx  s  a
        tbl[0]  = '{"reset",      2'b11, 1, 1, 1, 0, 0, 0, 0, 0, 4'd0, 3'd0, 0, 0};
        tbl[1]  = '{"s1_19",      2'b01, 1, 1, 1, 0, 0, 0, 0, 19, 4'd0, 3'd0, 0, 0};
        tbl[2]  = '{"s1_20",      2'b01, 1, 1, 1, 0, 0, 0, 0, 1, 4'd1, 3'd1, 1, 0};
        tbl[3]  = '{"s1_hold",    2'b01, 1, 1, 1, 0, 0, 0, 0, 5, 4'd1, 3'd1, 0, 0};
        tbl[4]  = '{"done_song",  2'b11, 1, 1, 1, 0, 1, 0, 0, 0, 4'd0, 3'd1, 0, 0};
        tbl[5]  = '{"idle",       2'b11, 1, 1, 1, 0, 0, 0, 0, 0, 4'd0, 3'd1, 0, 0};
        tbl[6]  = '{"s0mk_19",    2'b10, 1, 0, 1, 0, 0, 0, 0, 19, 4'd0, 3'd1, 0, 0};
        tbl[7]  = '{"s0mk_20",    2'b10, 1, 0, 1, 0, 0, 0, 0, 1, 4'd4, 3'd1, 1, 0};
        tbl[8]  = '{"stop_mk",    2'b11, 1, 1, 0, 0, 0, 0, 0, 20, 4'd0, 3'd1, 0, 1};
        tbl[9]  = '{"abort_end",  2'b11, 1, 1, 0, 0, 0, 0, 0, 0, 4'd0, 3'd1, 0, 0};
        tbl[10] = '{"prec_inv",   2'b11, 0, 1, 1, 0, 0, 0, 0, 20, 4'd0, 3'd1, 0, 0};
        tbl[11] = '{"prec_rel",   2'b11, 1, 1, 1, 1, 0, 0, 0, 0, 4'd0, 3'd1, 0, 0};
        tbl[12] = '{"prec_val",   2'b11, 0, 1, 1, 1, 0, 0, 0, 20, 4'd3, 3'd1, 1, 0};
        tbl[13] = '{"s0_in_prec", 2'b10, 1, 1, 1, 1, 0, 0, 0, 20, 4'd3, 3'd1, 0, 0};
        tbl[14] = '{"ds_in_prec", 2'b11, 1, 1, 1, 1, 1, 0, 0, 0, 4'd3, 3'd1, 0, 0};
        tbl[15] = '{"done_pb",    2'b11, 1, 1, 1, 1, 0, 1, 0, 0, 4'd0, 3'd1, 0, 0};
        tbl[16] = '{"make",       2'b11, 1, 0, 1, 1, 0, 0, 0, 20, 4'd4, 3'd1, 1, 0};
        tbl[17] = '{"stop_19",    2'b11, 1, 1, 0, 1, 0, 0, 0, 19, 4'd4, 3'd1, 0, 0};
        tbl[18] = '{"stop_done",  2'b11, 1, 1, 0, 1, 0, 0, 1, 1, 4'd0, 3'd1, 0, 0};
        tbl[19] = '{"release",    2'b11, 1, 1, 1, 1, 0, 0, 0, 0, 4'd0, 3'd1, 0, 0};
        tbl[20] = '{"s0_19",      2'b10, 1, 1, 1, 1, 0, 0, 0, 19, 4'd0, 3'd1, 0, 0};
        tbl[21] = '{"bounce",     2'b11, 1, 1, 1, 1, 0, 0, 0, 1, 4'd0, 3'd1, 0, 0};
        tbl[22] = '{"s0_19b",     2'b10, 1, 1, 1, 1, 0, 0, 0, 19, 4'd0, 3'd1, 0, 0};
        tbl[23] = '{"s0_20",      2'b10, 1, 1, 1, 1, 0, 0, 0, 1, 4'd1, 3'd0, 1, 0};

        reset = 1'b1;
        tick_1khz = 1'b0;
        song_n = 2'b11;
        {prec_n, make_n, stop_n} = 3'b111;
        {rv, ds, dp, dr} = 4'b0000;
        cyc(2);
        chk_out("in_reset", 4'd0, 3'd0, 1'b0, 1'b0);
        chk("in_reset.dbg", debugString, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            song_n = tbl[i].song_n;
            prec_n = tbl[i].prec_n;
            make_n = tbl[i].make_n;
            stop_n = tbl[i].stop_n;
            rv     = tbl[i].rv;
            ds     = tbl[i].ds;
            dp     = tbl[i].dp;
            dr     = tbl[i].dr;
            if (tbl[i].ticks == 0) cyc(1);
            else ticks(tbl[i].ticks);
            chk_out(tbl[i].name, tbl[i].st, tbl[i].idx, tbl[i].start,
                    tbl[i].abort);
        end
        {ds, dp, dr} = 3'b000;

        // Reset mid PLAY_SONG with song 0 held through release.
        reset = 1'b1;
        cyc(1);
        chk_out("rst_mid", 4'd0, 3'd0, 1'b0, 1'b0);
        chk("rst_mid.dbg", debugString, 32'h0);
        reset = 1'b0;
        ticks(19);
        chk_out("held_19", 4'd0, 3'd0, 1'b0, 1'b0);
        ticks(1);
        chk_out("held_20", 4'd1, 3'd0, 1'b1, 1'b0);
        ticks(3);
        chk("elapsed3.dbg", debugString, 32'h0100_0003);
        ticks(30);
        chk_out("held_more", 4'd1, 3'd0, 1'b0, 1'b0);
        song_n = 2'b11;
        ds = 1'b1;
        cyc(1);
        ds = 1'b0;
        chk_out("rst_done", 4'd0, 3'd0, 1'b0, 1'b0);

        // Long active mode: default timeout never trips here.
        song_n = 2'b01;
        ticks(20);
        chk_out("long_entry", 4'd1, 3'd1, 1'b1, 1'b0);
        song_n = 2'b11;
        ticks(5);
        cyc(1);
        chk_out("no_timeout", 4'd1, 3'd1, 1'b0, 1'b0);
        chk("no_timeout.dbg", debugString, 32'h0101_0005);
`ifdef MUSICBOX_WATCHDOG_EN
        chk("wd.state", 32'(wd_state), 32'd8);
        make_n = 1'b0;
        ticks(20);
        make_n = 1'b1;
        chk("wd.held", 32'(wd_state), 32'd8);
        chk("wd.nostart", 32'(wd_start), 32'd0);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("wd.reset", 32'(wd_state), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
